// File: rtl/rcvr_buf_if.sv
// Serial-in / word-out bus between the line interface, rcvr_buf and the word consumer.
// The master side drives the serial bit and the pop request. The slave side returns the FIFO status and the head word.
interface rcvr_buf_if #(
   parameter int DATA_WIDTH = 8,
   parameter int CW         = 3
);
   logic                  data_in;
   logic                  reading;
   logic                  ready;
   logic                  full;
   logic                  overrun;
   logic [CW-1:0]         count;
   logic [DATA_WIDTH-1:0] data_out;

   modport master (output data_in, reading,
                   input  ready, full, overrun, count, data_out);
   modport slave  (input  data_in, reading,
                   output ready, full, overrun, count, data_out);
endinterface

// File: rtl/rcvr_buf.sv
// Serial packet receiver: slides a window over the bit stream looking for HEAD and captures the body word that follows.
// Completed words are queued in a DEPTH-entry show-ahead FIFO with registered status outputs.
module rcvr_buf #(
   parameter int                    DATA_WIDTH = 8,
   parameter int                    HEAD_WIDTH = 8,
   parameter logic [HEAD_WIDTH-1:0] HEAD       = 8'hA5,
   parameter int                    DEPTH      = 4,
   parameter int                    CW         = $clog2(DEPTH+1)
) (
   input  logic      clock,
   input  logic      reset,
   rcvr_buf_if.slave bus
);
   localparam int PW  = $clog2(DEPTH);
   localparam int HFW = $clog2(HEAD_WIDTH+1);
   localparam int BCW = $clog2(DATA_WIDTH);

   typedef enum logic {HUNT, BODY} state_e;

   state_e                state_q, state_d;
   // Only the older HEAD_WIDTH-1 header bits are stored, because the newest bit is always the live data_in.
   // The body register is one bit short for the same reason.
   logic [HEAD_WIDTH-2:0] hsr_q, hsr_d;
   logic [HFW-1:0]        hfill_q, hfill_d;
   logic [DATA_WIDTH-2:0] bsr_q, bsr_d;
   logic [BCW-1:0]        bcnt_q, bcnt_d;
   logic [PW-1:0]         wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CW-1:0]         count_q, count_d;
   logic                  ready_q, ready_d, full_q, full_d, overrun_q, overrun_d;
   logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   logic [HEAD_WIDTH-1:0] hcand;
   logic [DATA_WIDTH-1:0] push_word;
   logic                  push_req, do_push, pop;

   always_comb begin
      state_d   = state_q;
      hsr_d     = hsr_q;
      hfill_d   = hfill_q;
      bsr_d     = bsr_q;
      bcnt_d    = bcnt_q;
      push_req  = 1'b0;
      hcand     = {hsr_q, bus.data_in};
      push_word = {bsr_q, bus.data_in};
      case (state_q)
         HUNT: begin
            hsr_d   = hcand[HEAD_WIDTH-2:0];
            hfill_d = (hfill_q == HFW'(HEAD_WIDTH)) ? hfill_q : hfill_q + HFW'(1);
            // The fill gate keeps the cleared register from matching an all-zero HEAD.
            if (hfill_q >= HFW'(HEAD_WIDTH-1) && hcand == HEAD) begin
               state_d = BODY;
               bcnt_d  = '0;
            end
         end
         BODY: begin
            bsr_d  = push_word[DATA_WIDTH-2:0];
            bcnt_d = bcnt_q + BCW'(1);
            if (bcnt_q == BCW'(DATA_WIDTH-1)) begin
               push_req = 1'b1;
               state_d  = HUNT;
               hsr_d    = '0;
               hfill_d  = '0;
               bcnt_d   = '0;
            end
         end
         default: state_d = HUNT;
      endcase

      pop       = bus.reading && ready_q;
      do_push   = push_req && (!full_q || pop);
      overrun_d = push_req && full_q && !pop;
      wptr_d    = do_push ? wptr_q + PW'(1) : wptr_q;
      rptr_d    = pop ? rptr_q + PW'(1) : rptr_q;
      count_d   = count_q;
      if (do_push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !do_push) count_d = count_q - CW'(1);
      ready_d   = (count_d != '0);
      full_d    = (count_d == CW'(DEPTH));
      // The head word bypasses the memory when the FIFO is empty, or when its only entry is popped as the new word arrives.
      if (count_d == '0)
         data_out_d = '0;
      else if (count_q == '0 || (count_q == CW'(1) && pop))
         data_out_d = push_word;
      else
         data_out_d = mem_q[rptr_d];
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= HUNT;
         hsr_q      <= '0;
         hfill_q    <= '0;
         bsr_q      <= '0;
         bcnt_q     <= '0;
         wptr_q     <= '0;
         rptr_q     <= '0;
         count_q    <= '0;
         ready_q    <= 1'b0;
         full_q     <= 1'b0;
         overrun_q  <= 1'b0;
         data_out_q <= '0;
      end else begin
         state_q    <= state_d;
         hsr_q      <= hsr_d;
         hfill_q    <= hfill_d;
         bsr_q      <= bsr_d;
         bcnt_q     <= bcnt_d;
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         count_q    <= count_d;
         ready_q    <= ready_d;
         full_q     <= full_d;
         overrun_q  <= overrun_d;
         data_out_q <= data_out_d;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset && do_push) mem_q[wptr_q] <= push_word;
   end

   assign bus.ready    = ready_q;
   assign bus.full     = full_q;
   assign bus.overrun  = overrun_q;
   assign bus.count    = count_q;
   assign bus.data_out = data_out_q;
endmodule

// File: tb/tb_rcvr_buf.sv
// Randomized and directed bench for rcvr_buf, compared every cycle against a bit-level packet/queue model.
module tb_rcvr_buf;
   localparam int             DW    = 8;
   localparam int             DEPTH = 4;
   localparam int             CW    = 3;
   localparam logic [7:0]     HEAD  = 8'hA5;

   logic clock = 1'b0;
   logic rst   = 1'b1;
   always #5 clock = ~clock;

   rcvr_buf_if #(.DATA_WIDTH(DW), .CW(CW)) bus ();

   rcvr_buf #(.DATA_WIDTH(DW), .HEAD_WIDTH(8), .HEAD(HEAD), .DEPTH(DEPTH), .CW(CW))
      dut (.clock(clock), .reset(rst), .bus(bus));

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Model: a packet parser over the raw bit history plus a bounded queue of words.
   bit         m_body;
   int         m_hist, m_hfill, m_bsr, m_bcnt;
   bit         m_ovr;
   logic [7:0] m_q [$];
   logic [7:0] rx  [$];

   task automatic model(input logic din, input logic rd, input logic r);
      bit pop, done;
      if (r) begin
         m_body = 0; m_hist = 0; m_hfill = 0; m_bsr = 0; m_bcnt = 0; m_ovr = 0;
         m_q.delete();
         return;
      end
      pop  = rd && (m_q.size() > 0);
      done = 0;
      if (!m_body) begin
         m_hist = ((m_hist << 1) | int'(din)) & 255;
         if (m_hfill < 8) m_hfill++;
         if (m_hfill == 8 && m_hist == int'(HEAD)) begin
            m_body = 1; m_bcnt = 0; m_bsr = 0;
         end
      end else begin
         m_bsr = ((m_bsr << 1) | int'(din)) & 255;
         m_bcnt++;
         if (m_bcnt == 8) begin
            done = 1; m_body = 0; m_hist = 0; m_hfill = 0;
         end
      end
      if (pop) void'(m_q.pop_front());
      m_ovr = 0;
      if (done) begin
         if (m_q.size() < DEPTH) m_q.push_back(m_bsr[7:0]);
         else m_ovr = 1;
      end
   endtask

   task automatic step(input logic din, input logic rd, input logic r = 1'b0);
      logic [7:0] exp_do;
      bus.data_in = din;
      bus.reading = rd;
      rst         = r;
      if (!r && rd && bus.ready) rx.push_back(bus.data_out);
      @(posedge clock);
      model(din, rd, r);
      #1;
      exp_do = (m_q.size() != 0) ? m_q[0] : 8'h00;
      chk("ready",    bus.ready,    m_q.size() != 0);
      chk("full",     bus.full,     m_q.size() == DEPTH);
      chk("count",    bus.count,    m_q.size());
      chk("overrun",  bus.overrun,  m_ovr);
      chk("data_out", bus.data_out, exp_do);
   endtask

   // rmode: 0 = no reads, 1 = read only on last body bit, 2 = random reads
   task automatic send_pkt(input logic [7:0] w, input int rmode);
      logic [7:0] h;
      logic       rd;
      h = HEAD;
      for (int i = 7; i >= 0; i--) step(h[i], (rmode == 2) ? ($urandom_range(0, 3) == 0) : 1'b0);
      for (int i = 7; i >= 0; i--) begin
         rd = (rmode == 2) ? ($urandom_range(0, 3) == 0) : (rmode == 1 && i == 0);
         step(w[i], rd);
      end
   endtask

   task automatic do_reset();
      step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b1);
   endtask

   initial begin
      string msg;
      bus.data_in = 1'b0;
      bus.reading = 1'b0;
      do_reset();

      // single packet then one pop
      send_pkt(8'h49, 0);
      chk("single_do", bus.data_out, 8'h49);
      chk("single_cnt", bus.count, 1);
      step(1'b0, 1'b1);
      chk("single_pop", bus.ready, 1'b0);

      // message stream with gaps and a lazy reader
      rx.delete();
      msg = "I Love Verilog";
      for (int c = 0; c < msg.len(); c++) begin
         int gap;
         gap = $urandom_range(0, 8);
         for (int g = 0; g < gap; g++) step(1'b0, $urandom_range(0, 3) == 0);
         send_pkt(msg[c], 2);
      end
      for (int k = 0; k < 40; k++) step(1'b0, 1'b1);
      chk("msg_len", rx.size(), msg.len());
      for (int c = 0; c < msg.len() && c < rx.size(); c++) chk("msg_char", rx[c], msg[c]);

      // overflow
      do_reset();
      for (int p = 1; p <= 5; p++) send_pkt(8'(p), 0);
      rx.delete();
      for (int k = 0; k < 4; k++) step(1'b0, 1'b1);
      step(1'b0, 1'b0);
      chk("ovf_rx0", rx.size() > 0 ? rx[0] : 8'hFF, 8'h01);
      chk("ovf_rx3", rx.size() > 3 ? rx[3] : 8'hFF, 8'h04);
      chk("ovf_empty", bus.ready, 1'b0);

      // full with simultaneous pop
      do_reset();
      for (int p = 1; p <= 4; p++) send_pkt(8'(p), 0);
      send_pkt(8'h05, 1);
      chk("fwp_cnt", bus.count, 4);
      chk("fwp_ovr", bus.overrun, 1'b0);
      rx.delete();
      for (int k = 0; k < 4; k++) step(1'b0, 1'b1);
      chk("fwp_rx0", rx.size() > 0 ? rx[0] : 8'hFF, 8'h02);
      chk("fwp_rx3", rx.size() > 3 ? rx[3] : 8'hFF, 8'h05);

      // false prefix and embedded header in the body
      do_reset();
      step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b1, 1'b0);
      send_pkt(8'hA5, 0);
      for (int k = 0; k < 20; k++) step(1'b0, 1'b0);
      chk("emb_cnt", bus.count, 1);
      chk("emb_do", bus.data_out, 8'hA5);

      // reset in the middle of a body
      do_reset();
      send_pkt(8'h11, 0);
      send_pkt(8'h22, 0);
      begin
         logic [7:0] h;
         h = HEAD;
         for (int i = 7; i >= 0; i--) step(h[i], 1'b0);
      end
      step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b1);
      chk("rst_cnt", bus.count, 0);
      send_pkt(8'h3C, 0);
      chk("rst_do", bus.data_out, 8'h3C);
      chk("rst_c1", bus.count, 1);

      // random bit soup with injected packets, random reads and rare resets
      do_reset();
      for (int k = 0; k < 3000; k++) begin
         if ($urandom_range(0, 29) == 0) send_pkt(8'($urandom), 2);
         else step(1'($urandom), $urandom_range(0, 5) == 0, $urandom_range(0, 799) == 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
